// File: rtl/wb_intercon_gen.sv
// Parametrised single-master, N-slave Wishbone interconnect with registered
// address decode, per-transaction timeout, bus-error response and error bookkeeping.
module wb_intercon_gen #(
  parameter int N_SLAVES = 5,
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int SEL_LO   = 12,
  parameter int SEL_W    = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m_STB,
  input  logic                   m_WE,
  input  logic [AW-1:0]          m_ADDR,
  input  logic [DW-1:0]          m_DAT_I,
  output logic [DW-1:0]          m_DAT_O,
  output logic                   m_ACK,
  output logic                   m_ERR,
  output logic [N_SLAVES-1:0]    s_STB,
  output logic                   s_WE,
  output logic [AW-1:0]          s_ADDR,
  output logic [DW-1:0]          s_DAT_O,
  input  logic [N_SLAVES*DW-1:0] s_DAT_I,
  input  logic [N_SLAVES-1:0]    s_ACK,
  output logic [15:0]            err_count,
  output logic [AW-1:0]          err_addr
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic [7:0]          timer_q, timer_d;
  logic [N_SLAVES-1:0] s_stb_q, s_stb_d;
  logic                s_we_q, s_we_d;
  logic [AW-1:0]       s_addr_q, s_addr_d;
  logic [AW-1:0]       m_addr_q, m_addr_d;
  logic [AW-1:0]       err_addr_q, err_addr_d;
  logic [DW-1:0]       s_dat_q, s_dat_d;
  logic [DW-1:0]       m_dat_q, m_dat_d;
  logic                m_ack_q, m_ack_d;
  logic                m_err_q, m_err_d;
  logic [15:0]         err_count_q, err_count_d;

  logic [SEL_W-1:0]    sel;
  logic [N_SLAVES-1:0] sel_onehot;
  logic                sel_valid;
  logic                ack_hit;
  logic [DW-1:0]       rd_data;
  logic [15:0]         err_count_inc;

  assign sel = m_ADDR[SEL_LO +: SEL_W];

  // An out-of-range select field yields an all-zero one-hot, which doubles as the decode error.
  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      sel_onehot[k] = (int'(sel) == k);
    end
  end

  assign sel_valid = |sel_onehot;

  // The registered one-hot strobe selects both the honoured ack and the read-data slot.
  assign ack_hit = |(s_ACK & s_stb_q);

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (s_stb_q[k]) rd_data = s_DAT_I[k*DW +: DW];
    end
  end

  assign err_count_inc = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    s_stb_d     = s_stb_q;
    s_we_d      = s_we_q;
    s_addr_d    = s_addr_q;
    s_dat_d     = s_dat_q;
    m_addr_d    = m_addr_q;
    m_dat_d     = m_dat_q;
    m_ack_d     = 1'b0;
    m_err_d     = 1'b0;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    unique case (state_q)
      IDLE: begin
        if (m_STB) begin
          s_we_d   = m_WE;
          s_addr_d = {{(AW-SEL_LO){1'b0}}, m_ADDR[SEL_LO-1:0]};
          s_dat_d  = m_DAT_I;
          m_addr_d = m_ADDR;
          if (sel_valid) begin
            s_stb_d = sel_onehot;
            timer_d = 8'd0;
            state_d = ACTIVE;
          end else begin
            m_err_d     = 1'b1;
            err_count_d = err_count_inc;
            err_addr_d  = m_ADDR;
            state_d     = DONE;
          end
        end
      end
      ACTIVE: begin
        if (ack_hit) begin
          if (!s_we_q) m_dat_d = rd_data;
          s_stb_d = '0;
          m_ack_d = 1'b1;
          state_d = DONE;
        end else if (timer_q == TIMEOUT_C) begin
          s_stb_d     = '0;
          m_err_d     = 1'b1;
          err_count_d = err_count_inc;
          err_addr_d  = m_addr_q;
          state_d     = DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      s_stb_q     <= '0;
      s_we_q      <= 1'b0;
      s_addr_q    <= '0;
      s_dat_q     <= '0;
      m_addr_q    <= '0;
      m_dat_q     <= '0;
      m_ack_q     <= 1'b0;
      m_err_q     <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      s_stb_q     <= s_stb_d;
      s_we_q      <= s_we_d;
      s_addr_q    <= s_addr_d;
      s_dat_q     <= s_dat_d;
      m_addr_q    <= m_addr_d;
      m_dat_q     <= m_dat_d;
      m_ack_q     <= m_ack_d;
      m_err_q     <= m_err_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign m_DAT_O   = m_dat_q;
  assign m_ACK     = m_ack_q;
  assign m_ERR     = m_err_q;
  assign s_STB     = s_stb_q;
  assign s_WE      = s_we_q;
  assign s_ADDR    = s_addr_q;
  assign s_DAT_O   = s_dat_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_wb_intercon_gen.sv
// Scoreboard bench for wb_intercon_gen: stimulus pushes expected master responses,
// a negedge monitor pops and compares them whenever m_ACK or m_ERR appears.
module tb_wb_intercon_gen;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            mStb, mWe;
  logic [AW-1:0]   mAddr;
  logic [DW-1:0]   mDatI, mDatO;
  logic            mAck, mErr;
  logic [N-1:0]    sStb;
  logic            sWe;
  logic [AW-1:0]   sAddr;
  logic [DW-1:0]   sDatO;
  logic [N*DW-1:0] sDatI;
  logic [N-1:0]    sAck, respAck;
  logic            junkAck3;
  logic [15:0]     errCount;
  logic [AW-1:0]   errAddr;

  typedef struct {
    bit          isErr;
    logic [31:0] data;
    int          cyc;
    logic [15:0] cnt;
    logic [31:0] eaddr;
  } resp_t;

  resp_t       expQ[$];
  resp_t       popped;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ackDelay[N];
  int          waitCnt[N];
  logic [15:0] modelCnt;
  logic [31:0] modelEaddr, modelRead;
  int          stbCycles;

  wb_intercon_gen dut (
    .clk       (clk),
    .reset     (reset),
    .m_STB     (mStb),
    .m_WE      (mWe),
    .m_ADDR    (mAddr),
    .m_DAT_I   (mDatI),
    .m_DAT_O   (mDatO),
    .m_ACK     (mAck),
    .m_ERR     (mErr),
    .s_STB     (sStb),
    .s_WE      (sWe),
    .s_ADDR    (sAddr),
    .s_DAT_O   (sDatO),
    .s_DAT_I   (sDatI),
    .s_ACK     (sAck),
    .err_count (errCount),
    .err_addr  (errAddr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  assign sAck = respAck | {1'b0, junkAck3, 3'b000};

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Slave k acks after ackDelay[k] strobed cycles; a negative delay means it never acks.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (sStb[k]) begin
        if (ackDelay[k] >= 0 && waitCnt[k] >= ackDelay[k]) respAck[k] = 1'b1;
        waitCnt[k]++;
      end else begin
        respAck[k] = 1'b0;
        waitCnt[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && (mAck || mErr)) begin
      checkOutput("ackErrExclusive", {63'b0, mAck & mErr}, 64'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResponse", 64'd1, 64'd0);
      end else begin
        popped = expQ.pop_front();
        checkOutput("respIsErr", {63'b0, mErr}, {63'b0, popped.isErr});
        checkOutput("respIsAck", {63'b0, mAck}, {63'b0, !popped.isErr});
        checkOutput("respCycle", 64'(cyc), 64'(popped.cyc));
        checkOutput("respData", {32'b0, mDatO}, {32'b0, popped.data});
        checkOutput("respErrCount", {48'b0, errCount}, {48'b0, popped.cnt});
        checkOutput("respErrAddr", {32'b0, errAddr}, {32'b0, popped.eaddr});
      end
    end
  end

  function automatic void expectResp(input bit isErr, input logic [31:0] addr,
                                     input logic [31:0] rdData, input bit isRead, input int atCyc);
    resp_t r;
    if (isErr) begin
      if (modelCnt != 16'hFFFF) modelCnt = modelCnt + 16'd1;
      modelEaddr = addr;
    end else if (isRead) begin
      modelRead = rdData;
    end
    r.isErr = isErr;
    r.data  = modelRead;
    r.cyc   = atCyc;
    r.cnt   = modelCnt;
    r.eaddr = modelEaddr;
    expQ.push_back(r);
  endfunction

  // Called on a negedge; returns one negedge later with m_STB already dropped.
  task automatic applyStimulus(input logic [31:0] addr, input bit we, input logic [31:0] data,
                               input bit isErr, input logic [31:0] rdData, input int latency);
    mStb  = 1'b1;
    mWe   = we;
    mAddr = addr;
    mDatI = data;
    expectResp(isErr, addr, rdData, !we, cyc + latency);
    @(negedge clk);
    mStb = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("responseTimeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset    = 1'b0;
    mStb     = 1'b0;
    mWe      = 1'b0;
    mAddr    = '0;
    mDatI    = '0;
    junkAck3 = 1'b0;
    respAck  = '0;
    for (int k = 0; k < N; k++) begin
      ackDelay[k] = 0;
      waitCnt[k]  = 0;
      sDatI[k*DW +: DW] = 32'hA000_0000 + 32'(k);
    end
    sDatI[2*DW +: DW] = 32'hDEAD_BEEF;
    modelCnt   = '0;
    modelEaddr = '0;
    modelRead  = '0;

    repeat (3) @(negedge clk);
    checkOutput("resetAck", {63'b0, mAck}, 64'd0);
    checkOutput("resetErr", {63'b0, mErr}, 64'd0);
    checkOutput("resetStb", {59'b0, sStb}, 64'd0);
    checkOutput("resetDatO", {32'b0, mDatO}, 64'd0);
    checkOutput("resetSAddr", {32'b0, sAddr}, 64'd0);
    checkOutput("resetErrCount", {48'b0, errCount}, 64'd0);
    checkOutput("resetErrAddr", {32'b0, errAddr}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Read slave 2, acked in its first strobe cycle.
    ackDelay[2] = 0;
    applyStimulus(32'h0000_2010, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);
    checkOutput("readStb", {59'b0, sStb}, 64'b00100);
    checkOutput("readSAddr", {32'b0, sAddr}, 64'h10);
    checkOutput("readSWe", {63'b0, sWe}, 64'd0);
    waitDrain();

    // Write slave 0, ack after 3 extra cycles; write data must hold across all 4 strobe cycles.
    ackDelay[0] = 3;
    applyStimulus(32'h0000_0004, 1'b1, 32'h1234, 1'b0, 32'h0, 5);
    for (int i = 0; i < 4; i++) begin
      checkOutput("writeStb", {63'b0, sStb[0]}, 64'd1);
      checkOutput("writeSWe", {63'b0, sWe}, 64'd1);
      checkOutput("writeSDatO", {32'b0, sDatO}, 64'h1234);
      @(negedge clk);
    end
    checkOutput("writeStbDropped", {59'b0, sStb}, 64'd0);
    waitDrain();

    // Select field 7 is outside the five populated slaves.
    applyStimulus(32'h0000_7000, 1'b0, 32'h0, 1'b1, 32'h0, 1);
    checkOutput("badDecodeStb", {59'b0, sStb}, 64'd0);
    waitDrain();

    // Slave 4 never acks; a stray ack from slave 3 must not end the transaction.
    ackDelay[4] = -1;
    applyStimulus(32'h0000_4008, 1'b0, 32'h0, 1'b1, 32'h0, 257);
    stbCycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (sStb[4]) stbCycles++;
      junkAck3 = (i >= 5 && i < 40);
      @(negedge clk);
    end
    checkOutput("timeoutStbCycles", 64'(stbCycles), 64'd256);
    waitDrain();

    // Three back-to-back reads with m_STB held high throughout.
    ackDelay[1] = 0;
    mStb = 1'b1;
    mWe  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mAddr = 32'h0000_1000 + 32'(i * 4);
      sDatI[1*DW +: DW] = 32'h1111_0000 + 32'(i);
      expectResp(1'b0, mAddr, 32'h1111_0000 + 32'(i), 1'b1, cyc + 2);
      repeat (3) @(negedge clk);
    end
    mStb = 1'b0;
    waitDrain();

    // Reset asserted while a read to slave 0 is outstanding.
    ackDelay[0] = -1;
    mStb  = 1'b1;
    mWe   = 1'b0;
    mAddr = 32'h0000_0020;
    @(negedge clk);
    mStb = 1'b0;
    checkOutput("preResetStb", {59'b0, sStb}, 64'b00001);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midResetStb", {59'b0, sStb}, 64'd0);
    checkOutput("midResetAck", {63'b0, mAck}, 64'd0);
    checkOutput("midResetErr", {63'b0, mErr}, 64'd0);
    checkOutput("midResetDatO", {32'b0, mDatO}, 64'd0);
    checkOutput("midResetErrCount", {48'b0, errCount}, 64'd0);
    checkOutput("midResetErrAddr", {32'b0, errAddr}, 64'd0);
    modelCnt   = '0;
    modelEaddr = '0;
    modelRead  = '0;
    @(negedge clk);
    reset = 1'b1;
    ackDelay[0] = 2;
    @(negedge clk);
    applyStimulus(32'h0000_0024, 1'b0, 32'h0, 1'b0, 32'hA000_0000, 4);
    waitDrain();

    // Preload the error counter at its ceiling, then one more error must leave it there.
    force dut.err_count_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.err_count_q;
    @(negedge clk);
    checkOutput("forcedErrCount", {48'b0, errCount}, 64'hFFFF);
    modelCnt = 16'hFFFF;
    applyStimulus(32'h0000_9ABC, 1'b0, 32'h0, 1'b1, 32'h0, 1);
    waitDrain();
    checkOutput("saturatedErrCount", {48'b0, errCount}, 64'hFFFF);

    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
